// File: rtl/dma_rd_pkg.sv
// Shared types and constants for the DMA read engine.
// Covers the FSM encoding, error codes, request types and a keep-mask popcount helper.
package dma_rd_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StWaitCpl = 2'd2,
      StFinish  = 2'd3
   } state_e;

   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_BAD_PARAM  = 3'd1;
   localparam logic [2:0] ERR_CPL_STATUS = 3'd2;
   localparam logic [2:0] ERR_LEN        = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT    = 3'd4;

   localparam logic [3:0] RQ_MEMRD = 4'b0000;
   localparam logic [3:0] RQ_MEMWR = 4'b0001;

   localparam logic [7:0] RD_TAG_DEFAULT = 8'h43;

   function automatic logic [5:0] keep_popcount(input logic [31:0] keep);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + {5'd0, keep[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/dma_rd_buffer.sv
// Completion landing buffer: MAX_DW x 32 storage with a keep-masked write at a DW offset
// and a registered read port returning one beat-wide group of DWs.
module dma_rd_buffer #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned MAX_DW     = 64
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      wr_en,
   input  logic [$clog2(MAX_DW+1)-1:0]               wr_off,
   input  logic [DATA_WIDTH/32-1:0]                  wr_keep,
   input  logic [DATA_WIDTH-1:0]                     wr_data,
   input  logic [$clog2(MAX_DW*32/DATA_WIDTH)-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]                     rd_data
);

   localparam int NDW = DATA_WIDTH / 32;
   localparam int AW  = $clog2(MAX_DW);

   logic [31:0]           mem [MAX_DW];
   logic [DATA_WIDTH-1:0] rd_word;

   // No reset on the storage: contents survive reset and new transfers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NDW; i++) begin
            if (wr_keep[i] && ((int'(wr_off) + i) < int'(MAX_DW))) begin
               mem[AW'(int'(wr_off) + i)] <= wr_data[i*32 +: 32];
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int j = 0; j < NDW; j++) begin
         rd_word[j*32 +: 32] = mem[AW'(int'(rd_addr) * NDW + j)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= rd_word;
      end
   end

endmodule

// File: rtl/dma_rd_engine.sv
// Single-request DMA read engine: issues one MemRd on RQ, gathers completions from RC
// into the landing buffer, and reports done/error with a sticky status.
module dma_rd_engine
   import dma_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned MAX_DW      = 64,
   parameter logic [7:0]  RD_TAG      = RD_TAG_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // control
   input  logic                       start,
   input  logic [63:0]                src_addr,
   input  logic [6:0]                 len_dw,
   input  logic [15:0]                cfg_requester_id,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [2:0]                 err_code,
   // requester request
   input  logic                       rq_ready,
   output logic                       rq_valid,
   output logic [3:0]                 rq_type,
   output logic                       rq_sop,
   output logic                       rq_last,
   output logic [63:0]                rq_addr,
   output logic [10:0]                rq_dword_count,
   output logic [7:0]                 rq_tag,
   output logic [15:0]                rq_requester_id,
   output logic [2:0]                 rq_tc,
   output logic [DATA_WIDTH-1:0]      rq_wr_data,
   output logic [DATA_WIDTH/32-1:0]   rq_wr_data_keep,
   // requester completion
   input  logic                       rc_desc_valid,
   input  logic [7:0]                 rc_tag,
   input  logic [2:0]                 rc_status,
   input  logic                       rc_request_completed,
   input  logic                       rc_data_valid,
   input  logic                       rc_data_sop,
   input  logic                       rc_data_eop,
   input  logic [DATA_WIDTH-1:0]      rc_payload,
   input  logic [DATA_WIDTH/32-1:0]   rc_payload_keep,
   // buffer read
   input  logic [2:0]                 buf_rd_addr,
   output logic [DATA_WIDTH-1:0]      buf_rd_data
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

   state_e        state_q, state_d;
   logic [63:0]   addr_q, addr_d;
   logic [6:0]    len_q, len_d;
   logic [6:0]    rx_dw_q, rx_dw_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [2:0]    err_code_q, err_code_d;
   logic          in_cpl_q, in_cpl_d;

   logic          bad_param;
   logic          sop_hit;
   logic          cont_hit;
   logic [5:0]    keep_pop;
   logic [7:0]    beat_sum;
   logic          buf_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         len_q      <= '0;
         rx_dw_q    <= '0;
         timer_q    <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
         in_cpl_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         rx_dw_q    <= rx_dw_d;
         timer_q    <= timer_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         in_cpl_q   <= in_cpl_d;
      end
   end

   // A request may not cross a 4 KB boundary: DW offset within the page plus length <= 1024.
   assign bad_param = (len_dw == 7'd0) ||
                      (32'(len_dw) > MAX_DW) ||
                      (src_addr[1:0] != 2'b00) ||
                      (({1'b0, src_addr[11:2]} + {4'd0, len_dw}) > 11'd1024);

   // sop beats are only ours when the descriptor matches; later beats follow an accepted sop.
   assign sop_hit  = rc_data_valid & rc_data_sop & rc_desc_valid & (rc_tag == RD_TAG);
   assign cont_hit = rc_data_valid & ~rc_data_sop & in_cpl_q;
   assign keep_pop = keep_popcount(32'(rc_payload_keep));
   assign beat_sum = {1'b0, rx_dw_q} + {2'b00, keep_pop};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      rx_dw_d    = rx_dw_q;
      timer_d    = timer_q;
      done_d     = done_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      in_cpl_d   = 1'b0;
      buf_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               done_d     = 1'b0;
               error_d    = 1'b0;
               err_code_d = ERR_NONE;
               rx_dw_d    = '0;
               timer_d    = '0;
               if (bad_param) begin
                  state_d    = StFinish;
                  err_code_d = ERR_BAD_PARAM;
               end else begin
                  addr_d  = src_addr;
                  len_d   = len_dw;
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            if (rq_ready) begin
               state_d = StWaitCpl;
            end
         end
         StWaitCpl: begin
            in_cpl_d = in_cpl_q;
            if (sop_hit && (rc_status != 3'd0)) begin
               state_d    = StFinish;
               err_code_d = ERR_CPL_STATUS;
               in_cpl_d   = 1'b0;
            end else if (sop_hit || cont_hit) begin
               // An accepted beat takes priority over an expiring timer.
               timer_d = '0;
               if (beat_sum > {1'b0, len_q}) begin
                  state_d    = StFinish;
                  err_code_d = ERR_LEN;
                  in_cpl_d   = 1'b0;
               end else begin
                  buf_we   = 1'b1;
                  rx_dw_d  = beat_sum[6:0];
                  in_cpl_d = ~rc_data_eop;
                  if (rc_data_eop) begin
                     if (beat_sum == {1'b0, len_q}) begin
                        state_d = StFinish;
                     end else if (rc_request_completed) begin
                        state_d    = StFinish;
                        err_code_d = ERR_LEN;
                     end
                  end
               end
            end else if (timer_q == TIMER_LAST) begin
               state_d    = StFinish;
               err_code_d = ERR_TIMEOUT;
               in_cpl_d   = 1'b0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StFinish: begin
            done_d  = 1'b1;
            error_d = (err_code_q != ERR_NONE);
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      rq_valid        = 1'b0;
      rq_type         = 4'b0000;
      rq_sop          = 1'b0;
      rq_last         = 1'b0;
      rq_addr         = '0;
      rq_dword_count  = '0;
      rq_tag          = '0;
      rq_requester_id = '0;
      rq_tc           = '0;
      rq_wr_data      = '0;
      rq_wr_data_keep = '0;
      if (state_q == StReq) begin
         rq_valid        = 1'b1;
         rq_type         = RQ_MEMRD;
         rq_sop          = 1'b1;
         rq_last         = 1'b1;
         rq_addr         = addr_q;
         rq_dword_count  = {4'd0, len_q};
         rq_tag          = RD_TAG;
         rq_requester_id = cfg_requester_id;
      end
   end

   assign busy     = (state_q == StReq) || (state_q == StWaitCpl);
   assign done     = done_q;
   assign error    = error_q;
   assign err_code = err_code_q;

   dma_rd_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_DW     (MAX_DW)
   ) u_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (buf_we),
      .wr_off  (rx_dw_q),
      .wr_keep (rc_payload_keep),
      .wr_data (rc_payload),
      .rd_addr (buf_rd_addr),
      .rd_data (buf_rd_data)
   );

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed bench for dma_rd_engine: expected requests queued at start, buffer contents
// tracked in a shadow model fed by the beats the bench expects to be accepted.
module tb_dma_rd_engine;
   import dma_rd_pkg::*;

   localparam int TO = 65535;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [63:0]  src_addr;
   logic [6:0]   len_dw;
   logic [15:0]  cfg_requester_id;
   logic         busy, done, error;
   logic [2:0]   err_code;
   logic         rq_ready, rq_valid, rq_sop, rq_last;
   logic [3:0]   rq_type;
   logic [63:0]  rq_addr;
   logic [10:0]  rq_dword_count;
   logic [7:0]   rq_tag;
   logic [15:0]  rq_requester_id;
   logic [2:0]   rq_tc;
   logic [255:0] rq_wr_data;
   logic [7:0]   rq_wr_data_keep;
   logic         rc_desc_valid, rc_request_completed, rc_data_valid, rc_data_sop, rc_data_eop;
   logic [7:0]   rc_tag;
   logic [2:0]   rc_status;
   logic [255:0] rc_payload;
   logic [7:0]   rc_payload_keep;
   logic [2:0]   buf_rd_addr;
   logic [255:0] buf_rd_data;

   always #5 clk = ~clk;

   dma_rd_engine dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .start                (start),
      .src_addr             (src_addr),
      .len_dw               (len_dw),
      .cfg_requester_id     (cfg_requester_id),
      .busy                 (busy),
      .done                 (done),
      .error                (error),
      .err_code             (err_code),
      .rq_ready             (rq_ready),
      .rq_valid             (rq_valid),
      .rq_type              (rq_type),
      .rq_sop               (rq_sop),
      .rq_last              (rq_last),
      .rq_addr              (rq_addr),
      .rq_dword_count       (rq_dword_count),
      .rq_tag               (rq_tag),
      .rq_requester_id      (rq_requester_id),
      .rq_tc                (rq_tc),
      .rq_wr_data           (rq_wr_data),
      .rq_wr_data_keep      (rq_wr_data_keep),
      .rc_desc_valid        (rc_desc_valid),
      .rc_tag               (rc_tag),
      .rc_status            (rc_status),
      .rc_request_completed (rc_request_completed),
      .rc_data_valid        (rc_data_valid),
      .rc_data_sop          (rc_data_sop),
      .rc_data_eop          (rc_data_eop),
      .rc_payload           (rc_payload),
      .rc_payload_keep      (rc_payload_keep),
      .buf_rd_addr          (buf_rd_addr),
      .buf_rd_data          (buf_rd_data)
   );

   typedef struct packed {
      logic [63:0] addr;
      logic [10:0] cnt;
   } rq_exp_t;

   int          vectors = 0;
   int          miscompares = 0;
   rq_exp_t     rq_q[$];
   logic [31:0] shadow [64];
   int          tb_rx;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] pay(input logic [31:0] base);
      logic [255:0] p;
      for (int i = 0; i < 8; i++) p[i*32 +: 32] = base + 32'(i);
      return p;
   endfunction

   task automatic start_xfer(input logic [63:0] a, input logic [6:0] l, input bit push);
      start    = 1'b1;
      src_addr = a;
      len_dw   = l;
      tb_rx    = 0;
      if (push) rq_q.push_back('{addr: a, cnt: {4'd0, l}});
      tick();
      start = 1'b0;
   endtask

   task automatic expect_rq(input string tag);
      rq_exp_t e;
      int n = 0;
      while (!(rq_valid && rq_ready) && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_handshake"}, 256'(rq_valid && rq_ready), 256'(1));
      e = (rq_q.size() > 0) ? rq_q.pop_front() : '0;
      chk({tag, "_addr"}, 256'(rq_addr), 256'(e.addr));
      chk({tag, "_count"}, 256'(rq_dword_count), 256'(e.cnt));
      chk({tag, "_tag"}, 256'(rq_tag), 256'(8'h43));
      chk({tag, "_type"}, 256'(rq_type), 256'(4'b0000));
      chk({tag, "_sop_last"}, 256'({rq_sop, rq_last}), 256'(2'b11));
      chk({tag, "_rid"}, 256'(rq_requester_id), 256'(16'h0A10));
      chk({tag, "_tc_keep"}, 256'({rq_tc, rq_wr_data_keep}), 256'(0));
      chk({tag, "_wr_data"}, rq_wr_data, 256'(0));
      tick();
   endtask

   task automatic send_beat(input logic sop, input logic eop, input logic desc,
                            input logic [7:0] tag, input logic [2:0] st, input logic cmpl,
                            input logic [7:0] keep, input logic [255:0] data, input bit accept);
      int pc = 0;
      rc_data_valid        = 1'b1;
      rc_data_sop          = sop;
      rc_data_eop          = eop;
      rc_desc_valid        = desc;
      rc_tag               = tag;
      rc_status            = st;
      rc_request_completed = cmpl;
      rc_payload_keep      = keep;
      rc_payload           = data;
      tick();
      rc_data_valid = 1'b0;
      rc_data_sop   = 1'b0;
      rc_data_eop   = 1'b0;
      rc_desc_valid = 1'b0;
      rc_request_completed = 1'b0;
      if (accept) begin
         for (int i = 0; i < 8; i++) begin
            if (keep[i]) begin
               shadow[tb_rx + i] = data[i*32 +: 32];
               pc++;
            end
         end
         tb_rx += pc;
      end
   endtask

   task automatic wait_done(input string tag, input int bound, output int cycles);
      cycles = 0;
      while (!done && cycles < bound) begin
         tick();
         cycles++;
      end
      chk({tag, "_done"}, 256'(done), 256'(1));
   endtask

   task automatic chk_buf(input string tag, input logic [2:0] a, input logic [7:0] m);
      logic [255:0] e = '0;
      logic [255:0] o = '0;
      buf_rd_addr = a;
      tick();
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            e[i*32 +: 32] = shadow[int'(a) * 8 + i];
            o[i*32 +: 32] = buf_rd_data[i*32 +: 32];
         end
      end
      chk(tag, o, e);
   endtask

   typedef struct packed {
      logic [63:0] addr;
      logic [6:0]  len;
   } bad_t;

   initial begin
      int   cyc;
      bad_t bad_tab [4];
      bad_tab[0] = '{addr: 64'h1000, len: 7'd0};
      bad_tab[1] = '{addr: 64'hFF8,  len: 7'd4};
      bad_tab[2] = '{addr: 64'h1000, len: 7'd65};
      bad_tab[3] = '{addr: 64'h1002, len: 7'd4};

      rst_n = 1'b0;
      start = 1'b0;
      src_addr = '0;
      len_dw = '0;
      cfg_requester_id = 16'h0A10;
      rq_ready = 1'b0;
      rc_desc_valid = 1'b0;
      rc_tag = '0;
      rc_status = '0;
      rc_request_completed = 1'b0;
      rc_data_valid = 1'b0;
      rc_data_sop = 1'b0;
      rc_data_eop = 1'b0;
      rc_payload = '0;
      rc_payload_keep = '0;
      buf_rd_addr = '0;
      tb_rx = 0;
      repeat (2) tick();
      chk("rst_status", 256'({busy, done, error, err_code}), 256'(0));
      chk("rst_rq_valid", 256'(rq_valid), 256'(0));
      rst_n = 1'b1;
      tick();

      // single beat
      rq_ready = 1'b1;
      start_xfer(64'h1000, 7'd8, 1'b1);
      expect_rq("s1_rq");
      chk("s1_busy", 256'(busy), 256'(1));
      send_beat(1, 1, 1, 8'h43, 3'd0, 1, 8'hFF, pay(32'h1111_0000), 1);
      wait_done("s1", 10, cyc);
      chk("s1_err", 256'({error, err_code, busy}), 256'(0));
      chk_buf("s1_buf0", 3'd0, 8'hFF);
      repeat (5) tick();
      chk("s1_done_sticky", 256'(done), 256'(1));

      // split completion
      start_xfer(64'h2000, 7'd20, 1'b1);
      expect_rq("s2_rq");
      send_beat(1, 0, 1, 8'h43, 3'd0, 0, 8'hFF, pay(32'h2222_0000), 1);
      send_beat(0, 1, 0, 8'h00, 3'd0, 0, 8'hFF, pay(32'h2222_0100), 1);
      repeat (2) tick();
      chk("s2_mid_state", 256'({busy, done}), 256'(2'b10));
      send_beat(1, 1, 1, 8'h43, 3'd0, 1, 8'h0F, pay(32'h2222_0200), 1);
      wait_done("s2", 10, cyc);
      chk("s2_err", 256'({error, err_code}), 256'(0));
      chk_buf("s2_buf0", 3'd0, 8'hFF);
      chk_buf("s2_buf1", 3'd1, 8'hFF);
      chk_buf("s2_buf2", 3'd2, 8'h0F);

      // bad parameters never issue a request
      for (int k = 0; k < 4; k++) begin
         start_xfer(bad_tab[k].addr, bad_tab[k].len, 1'b0);
         chk($sformatf("s3_bad%0d_novalid", k), 256'({rq_valid, busy}), 256'(0));
         wait_done($sformatf("s3_bad%0d", k), 10, cyc);
         chk($sformatf("s3_bad%0d_code", k), 256'({error, err_code}), 256'({1'b1, ERR_BAD_PARAM}));
      end

      // page-end boundary is legal; error completion status
      start_xfer(64'hFF0, 7'd4, 1'b1);
      expect_rq("s3_st_rq");
      send_beat(1, 1, 1, 8'h43, 3'd1, 1, 8'h0F, pay(32'h3333_0000), 0);
      wait_done("s3_st", 10, cyc);
      chk("s3_st_code", 256'({error, err_code}), 256'({1'b1, ERR_CPL_STATUS}));

      // overlong beat is not written
      start_xfer(64'h3000, 7'd4, 1'b1);
      expect_rq("s3_len_rq");
      send_beat(1, 1, 1, 8'h43, 3'd0, 1, 8'hFF, pay(32'h4444_0000), 0);
      wait_done("s3_len", 10, cyc);
      chk("s3_len_code", 256'({error, err_code}), 256'({1'b1, ERR_LEN}));
      chk_buf("s3_len_buf0", 3'd0, 8'hFF);

      // foreign tag dropped, then timeout
      start_xfer(64'h4000, 7'd8, 1'b1);
      expect_rq("s4_rq");
      send_beat(1, 1, 1, 8'h42, 3'd0, 1, 8'hFF, pay(32'h5555_0000), 0);
      repeat (2) tick();
      chk("s4_foreign_state", 256'({busy, done}), 256'(2'b10));
      wait_done("s4_to", TO + 50, cyc);
      chk("s4_to_code", 256'({error, err_code}), 256'({1'b1, ERR_TIMEOUT}));
      chk("s4_to_window", 256'((cyc >= TO - 10) && (cyc <= TO + 5)), 256'(1));
      chk_buf("s4_buf0", 3'd0, 8'hFF);

      // backpressure with a start pulse while busy
      rq_ready = 1'b0;
      start_xfer(64'h5000, 7'd8, 1'b1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("s5_hold%0d_valid", k), 256'(rq_valid), 256'(1));
         chk($sformatf("s5_hold%0d_fields", k), 256'({rq_addr, rq_dword_count, rq_tag}),
             256'({64'h5000, 11'd8, 8'h43}));
         if (k == 2) begin
            start    = 1'b1;
            src_addr = 64'h6000;
            len_dw   = 7'd16;
         end
         tick();
         start = 1'b0;
      end
      rq_ready = 1'b1;
      expect_rq("s5_rq");
      start = 1'b1;
      src_addr = 64'h7000;
      len_dw = 7'd8;
      tick();
      start = 1'b0;
      chk("s5_busy_start_ignored", 256'({rq_valid, busy}), 256'(2'b01));
      tb_rx = 0;
      send_beat(1, 0, 1, 8'h43, 3'd0, 0, 8'hFF, pay(32'h6666_0000), 1);

      // asynchronous reset mid-completion
      #2 rst_n = 1'b0;
      #1;
      chk("s5_rst_status", 256'({busy, done, error, err_code}), 256'(0));
      chk("s5_rst_rq", 256'({rq_valid, rq_addr, rq_dword_count, rq_tag}), 256'(0));
      tick();
      rst_n = 1'b1;
      tick();
      send_beat(0, 1, 0, 8'h00, 3'd0, 1, 8'hFF, pay(32'h7777_0000), 0);
      send_beat(1, 1, 1, 8'h43, 3'd0, 1, 8'hFF, pay(32'h7777_0100), 0);
      repeat (2) tick();
      chk("s5_late_dropped", 256'({busy, done, error, rq_valid}), 256'(0));
      chk_buf("s5_buf0", 3'd0, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dma_rd_engine.md
DMA_RD_ENGINE -- requirements
Module: dma_rd_engine

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 256, beat width in bits; MAX_DW 64, max read length in DWords; RD_TAG 8'h43, tag for read requests; TIMEOUT_CYC 65535, completion timeout in cycles.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  reset.
REQ-003 Control ports SHALL be: start in 1, launch pulse; src_addr in 64, host IOVA (byte); len_dw in 7, length in DWords; cfg_requester_id in 16, own BDF; busy out 1; done out 1, sticky; error out 1, sticky; err_code out 3.
REQ-004 RQ ports SHALL be: rq_ready in 1; rq_valid out 1; rq_type out 4; rq_sop out 1; rq_last out 1; rq_addr out 64; rq_dword_count out 11; rq_tag out 8; rq_requester_id out 16; rq_tc out 3; rq_wr_data out DATA_WIDTH; rq_wr_data_keep out DATA_WIDTH/32.
REQ-005 RC ports SHALL be: rc_desc_valid in 1; rc_tag in 8; rc_status in 3; rc_request_completed in 1; rc_data_valid in 1; rc_data_sop in 1; rc_data_eop in 1; rc_payload in DATA_WIDTH; rc_payload_keep in DATA_WIDTH/32.
REQ-006 Buffer read ports SHALL be: buf_rd_addr in 3, 8-DW word index; buf_rd_data out DATA_WIDTH, registered.

Function
REQ-007 States SHALL be IDLE, REQ, WAIT_CPL, FINISH.
REQ-008 In IDLE, start SHALL clear done, error, err_code, rx_dw, and the timer.
- Bad parameters go to FINISH with err_code 1. Bad parameters are: len_dw 0; len_dw > MAX_DW; src_addr[1:0] != 0; or src_addr[11:2] + len_dw > 1024 (4 KB crossing).
- Otherwise the engine latches src_addr/len_dw and goes to REQ.
REQ-009 start SHALL be ignored while busy; busy SHALL be 1 in REQ and WAIT_CPL only.
REQ-010 In REQ, rq_valid SHALL be 1 with fields stable until the rq_valid & rq_ready cycle, then the engine goes to WAIT_CPL. Fields:
- rq_type 4'b0000 (MemRd); rq_sop = rq_last = 1
- rq_addr latched address; rq_dword_count latched len; rq_tag RD_TAG
- rq_requester_id cfg_requester_id; rq_tc 0
- rq_wr_data 0; rq_wr_data_keep 0
REQ-011 rc_desc_valid SHALL coincide with the sop data beat. On it, tag/status are evaluated.
- Tag != RD_TAG, or state != WAIT_CPL: that completion, sop through eop, SHALL be dropped.
- rc_status != 0: go to FINISH with err_code 2.
REQ-012 Each accepted data beat SHALL write DW i (keep[i]=1, keep contiguous from bit 0) to buffer DW rx_dw+i, then advance rx_dw by popcount(keep).
REQ-013 If rx_dw + popcount(keep) > latched len, the beat SHALL NOT be written and the engine goes to FINISH with err_code 3.
REQ-014 On an accepted eop beat:
- rx_dw reaching len goes to FINISH with no error.
- rc_request_completed = 1 with rx_dw < len goes to FINISH with err_code 3.
REQ-015 The WAIT_CPL timer SHALL count cycles, reset on every accepted data beat, and on reaching TIMEOUT_CYC go to FINISH with err_code 4.
REQ-016 FINISH SHALL last one cycle, set done=1 (and error=1 if err_code != 0), then return to IDLE. done/error SHALL hold until the next accepted start.
REQ-017 If the timeout and a beat occur in the same cycle, the beat SHALL win.
REQ-018 buf_rd_data SHALL equal DWs {8a+7..8a} of address a, one cycle after buf_rd_addr is presented. It is readable anytime; mid-transfer reads return partial data.
REQ-019 The buffer SHALL NOT be cleared by start or reset; stale DWs beyond len are undefined.

Reset
REQ-020 Assertion of rst_n=0 SHALL asynchronously force IDLE, rq_valid 0, all RQ outputs 0, busy/done/error 0, err_code 0, rx_dw 0, and the timer 0, including mid-request or mid-completion.
REQ-021 Completion beats arriving after reset release SHALL be dropped as in REQ-011.

Structure
REQ-022 Package dma_rd_pkg SHALL hold:
- the state encoding
- err_code constants: NONE 0, BAD_PARAM 1, CPL_STATUS 2, LEN 3, TIMEOUT 4
- the RQ type constants MEMRD 4'b0000 and MEMWR 4'b0001
- RD_TAG default
REQ-023 The block SHALL contain one sub-module, dma_rd_buffer: MAX_DW x 32 storage, keep-masked DW write at an offset, and a registered 8-DW read port.

Verification
REQ-024 Scenario 1, single beat: start, addr 0x1000, len 8; rq_ready=1. Expected: one MemRd, dword_count 8, tag 0x43. Then one RC beat, status 0, keep 0xFF, eop, completed. Expected: done=1, error=0, buf word 0 = payload.
REQ-025 Scenario 2, split completion: len 20 returned as beats with keep 0xFF, 0xFF, 0x0F across two completions. Expected: DW0..19 placed contiguously, done after the final eop.
REQ-026 Scenario 3, errors: len 0 -> err 1 and no rq_valid; addr 0xFF8 with len 4 -> err 1; rc_status 3'b001 -> err 2; len 4 with keep 0xFF -> err 3 and the buffer unchanged.
REQ-027 Scenario 4, foreign and timeout: a completion with tag 0x42 SHALL be dropped; no valid completion for TIMEOUT_CYC cycles -> err 4, done=1.
REQ-028 Scenario 5, handshake and reset: rq_ready held 0 for 5 cycles -> rq_valid and fields stable throughout; start while busy -> ignored; rst_n low mid-WAIT_CPL -> IDLE with all outputs 0, and a late completion is dropped.
